mvm_engine: RTL and testbench

Parametrised matrix-vector multiply engine computing C[r] = sum over k of A[r][k]*B[k] for a ROWS x COLS matrix A and a COLS-element vector B. It fetches operands from the Avalon-MM read port of mem_wrapper, buffers them internally, runs ROWS parallel MAC lanes for COLS cycles, then holds the results.
It has a start/busy/done handshake and an accumulate mode (results carried across runs). It supersedes the fixed 8x8 lab top level.

---
 rtl/mvm_pkg.sv | 19 +
 rtl/mvm_mac_lane.sv | 32 +++
 rtl/mvm_engine.sv | 137 +++++++++++++
 tb/tb_mvm_engine.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared types and sizing helpers for the matrix-vector multiply engine.
package mvm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        COMPUTE,
        DONE
    } state_e;

    // Smallest accumulator that cannot overflow within one run.
    function automatic int acc_min(int data_width, int cols);
        return 2 * data_width + $clog2(cols);
    endfunction

    localparam int ACC_MIN = acc_min(8, 8);

endpackage

// File: rtl/mvm_mac_lane.sv
// One unsigned multiply-accumulate lane; accumulation wraps modulo 2^ACC_WIDTH.
module mvm_mac_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o
);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0]    acc_q;

    assign prod  = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
    assign acc_o = acc_q;

    // NOTE: sequential state is only ever assigned with <=, so every lane samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/mvm_engine.sv
// Matrix-vector multiply engine: fetches B and the A rows over an Avalon-MM read port,
// then runs ROWS parallel MAC lanes for COLS cycles and holds the results.
module mvm_engine
    import mvm_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic                       accumulate,
    output logic [ADDR_WIDTH-1:0]      mem_address,
    output logic                       mem_read,
    input  logic [COLS*DATA_WIDTH-1:0] mem_readdata,
    input  logic                       mem_readdatavalid,
    input  logic                       mem_waitrequest,
    output logic                       busy,
    output logic                       done,
    output logic [ROWS*ACC_WIDTH-1:0]  result
);

    localparam int WORD_W = COLS * DATA_WIDTH;
    localparam int FW     = $clog2(ROWS + 1);
    localparam int KW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(ROWS);
    localparam logic [KW-1:0] K_LAST = KW'(COLS - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [FW-1:0]           f_q;
    logic [KW-1:0]           k_q;
    logic                    busy_q, done_q;
    logic [WORD_W-1:0]       b_q;
    logic [WORD_W-1:0]       a_q [ROWS];
    logic [DATA_WIDTH-1:0]   b_el;
    logic [DATA_WIDTH-1:0]   a_el [ROWS];
    logic                    accept, lane_clr, lane_en;

    // A start during the done pulse lands in IDLE but must still be ignored.
    assign accept = (state_q == IDLE) && start && !done_q;
    assign busy   = busy_q;
    assign done   = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (accept) state_d = ISSUE;
            ISSUE:     if (!mem_waitrequest) state_d = WAIT_DATA;
            WAIT_DATA: if (mem_readdatavalid) state_d = (f_q == F_LAST) ? COMPUTE : ISSUE;
            COMPUTE:   if (k_q == K_LAST) state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_read    = (state_q == ISSUE);
        mem_address = base_q + ADDR_WIDTH'(f_q);
        lane_en     = (state_q == COMPUTE);
        lane_clr    = accept && !accumulate;
    end

    // NOTE: the operand buffers are ordinary registers and are reset, so a stale row never leaks into a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q <= '0;
            f_q    <= '0;
            k_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            b_q    <= '0;
            for (int r = 0; r < ROWS; r++) a_q[r] <= '0;
        end else begin
            done_q <= (state_q == DONE);
            if (accept) begin
                base_q <= base_addr;
                f_q    <= '0;
                busy_q <= 1'b1;
            end else if (state_q == DONE) begin
                busy_q <= 1'b0;
            end
            if (state_q == WAIT_DATA && mem_readdatavalid) begin
                if (f_q == '0) b_q <= mem_readdata;
                for (int r = 0; r < ROWS; r++) begin
                    if (f_q == FW'(r + 1)) a_q[r] <= mem_readdata;
                end
                if (f_q != F_LAST) f_q <= f_q + FW'(1);
                k_q <= '0;
            end
            if (state_q == COMPUTE) k_q <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
        end
    end

    // Column k of every buffered operand feeds the lanes this cycle.
    always_comb begin
        b_el = '0;
        for (int k = 0; k < COLS; k++) begin
            if (k_q == KW'(k)) b_el = b_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int r = 0; r < ROWS; r++) begin
            a_el[r] = '0;
            for (int k = 0; k < COLS; k++) begin
                if (k_q == KW'(k)) a_el[r] = a_q[r][k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        mvm_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (lane_clr),
            .en_i  (lane_en),
            .a_i   (a_el[r]),
            .b_i   (b_el),
            .acc_o (result[r*ACC_WIDTH +: ACC_WIDTH])
        );
    end

endmodule

// File: tb/tb_mvm_engine.sv
// Self-checking bench for mvm_engine: behavioural Avalon slave plus an arithmetic
// reference model of C = A*B with accumulate mode.
module tb_mvm_engine;

    localparam int DW   = 8;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int AW   = 24;
    localparam int ADW  = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 accumulate = 1'b0;
    logic [ADW-1:0]       base_addr = '0;
    logic [ADW-1:0]       mem_address;
    logic                 mem_read;
    logic [COLS*DW-1:0]   mem_readdata = '0;
    logic                 mem_readdatavalid = 1'b0;
    logic                 mem_waitrequest = 1'b0;
    logic                 busy, done;
    logic [ROWS*AW-1:0]   result;

    mvm_engine #(
        .DATA_WIDTH (DW),
        .ROWS       (ROWS),
        .COLS       (COLS),
        .ACC_WIDTH  (AW),
        .ADDR_WIDTH (ADW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .accumulate        (accumulate),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_waitrequest   (mem_waitrequest),
        .busy              (busy),
        .done              (done),
        .result            (result)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory image and slave controls (written by the stimulus block only).
    logic [COLS*DW-1:0] mem [64];
    int                 lat = 1;
    int                 stall_target = 0;
    logic [ADW-1:0]     stall_addr = '1;
    int                 inject_req = 0;

    // Slave-owned state.
    int                 stalls_done = 0;
    int                 hold_bad = 0;
    int                 inject_seen = 0;
    int                 pend_cnt = 0;
    logic [ADW-1:0]     pend_addr = '0;
    bit                 have_hold = 1'b0;
    logic [ADW-1:0]     hold_addr = '0;

    // Avalon slave: fixed read latency `lat`, optional waitrequest stall on stall_addr.
    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        if (!rst_n) pend_cnt = 0;
        if (inject_req != inject_seen) begin
            inject_seen       = inject_req;
            mem_readdatavalid = 1'b1;
            mem_readdata      = {$urandom, $urandom};
        end else if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = mem[pend_addr[5:0]];
            end
        end
        mem_waitrequest = 1'b0;
        if (rst_n && mem_read === 1'b1) begin
            if (stalls_done < stall_target && mem_address == stall_addr) begin
                if (have_hold) begin
                    if (mem_address !== hold_addr) hold_bad++;
                end else begin
                    have_hold = 1'b1;
                    hold_addr = mem_address;
                end
                mem_waitrequest = 1'b1;
                stalls_done++;
            end else begin
                if (have_hold) begin
                    if (mem_address !== hold_addr) hold_bad++;
                    have_hold = 1'b0;
                end
                pend_cnt  = lat;
                pend_addr = mem_address;
            end
        end
    end

    // Reference model: plain integer dot products, wrapped to AW bits.
    logic [AW-1:0] model_c [ROWS];

    function automatic int unsigned el(logic [COLS*DW-1:0] w, int k);
        logic [COLS*DW-1:0] t;
        t = w >> (k * DW);
        return int'(t[DW-1:0]);
    endfunction

    task automatic model_run(int base, bit acc);
        longint s;
        for (int r = 0; r < ROWS; r++) begin
            s = acc ? longint'(model_c[r]) : 64'd0;
            for (int k = 0; k < COLS; k++) begin
                s += longint'(el(mem[base + 1 + r], k)) * longint'(el(mem[base], k));
            end
            model_c[r] = AW'(s);
        end
    endtask

    function automatic logic [ROWS*AW-1:0] model_vec();
        logic [ROWS*AW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*AW +: AW] = model_c[r];
        return v;
    endfunction

    function automatic int exp_latency(int l, int stall);
        return 1 + (ROWS + 1) * (1 + l) + COLS + 1 + stall;
    endfunction

    task automatic fill_identity(int base);
        logic [COLS*DW-1:0] w;
        w = '0;
        for (int k = 0; k < COLS; k++) w[k*DW +: DW] = DW'(k + 1);
        mem[base] = w;
        for (int r = 0; r < ROWS; r++) begin
            w = '0;
            w[r*DW +: DW] = DW'(1);
            mem[base + 1 + r] = w;
        end
    endtask

    task automatic fill_const(int base, logic [COLS*DW-1:0] w);
        for (int i = 0; i <= ROWS; i++) mem[base + i] = w;
    endtask

    task automatic fill_random(int base);
        for (int i = 0; i <= ROWS; i++) mem[base + i] = {$urandom, $urandom};
    endtask

    int cyc;
    int busy_cyc;

    task automatic step();
        if (busy === 1'b1) busy_cyc++;
        @(negedge clk);
        cyc++;
    endtask

    task automatic launch(int base, bit acc);
        cyc        = 0;
        busy_cyc   = 0;
        base_addr  = ADW'(base);
        accumulate = acc;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && cyc < 1000) step();
    endtask

    task automatic finish_checks(string tag, int exp_lat);
        check({tag, "_latency"}, 256'(cyc), 256'(exp_lat));
        check({tag, "_busy_cycles"}, 256'(busy_cyc), 256'(exp_lat - 1));
        check({tag, "_busy_at_done"}, 256'(busy), 256'(0));
        check({tag, "_result"}, 256'(result), 256'(model_vec()));
    endtask

    task automatic run(string tag, int base, bit acc, int stall);
        model_run(base, acc);
        launch(base, acc);
        wait_done();
        finish_checks(tag, exp_latency(lat, stall));
        step();
        check({tag, "_done_pulse"}, 256'(done), 256'(0));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        for (int r = 0; r < ROWS; r++) model_c[r] = '0;

        repeat (3) @(negedge clk);
        check("rst_result", 256'(result), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_mem_read", 256'(mem_read), 256'(0));
        check("rst_mem_address", 256'(mem_address), 256'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Identity matrix: C[r] = r+1, then accumulate doubles, then clear restores.
        fill_identity(0);
        run("ident", 0, 1'b0, 0);
        check("ident_c0", 256'(result[0 +: AW]), 256'(1));
        check("ident_c7", 256'(result[7*AW +: AW]), 256'(8));
        run("ident_acc", 0, 1'b1, 0);
        check("ident_acc_c7", 256'(result[7*AW +: AW]), 256'(16));
        run("ident_clr", 0, 1'b0, 0);
        check("ident_clr_c3", 256'(result[3*AW +: AW]), 256'(4));

        // All elements 255: every lane gives 8*65025.
        fill_const(10, '1);
        run("allmax", 10, 1'b0, 0);
        check("allmax_value", 256'(result), 256'({ROWS{24'h07F008}}));

        // Three waitrequest cycles on the fetch at base+4.
        stall_addr   = ADW'(4);
        stall_target = stall_target + 3;
        run("stall", 0, 1'b0, 3);
        check("stall_count", 256'(stalls_done), 256'(3));
        check("stall_addr_hold", 256'(hold_bad), 256'(0));

        // Random operands with read latency 2.
        fill_random(20);
        lat = 2;
        run("rand_l2", 20, 1'b0, 0);
        lat = 1;
        fill_random(20);
        run("rand_l1", 20, 1'b0, 0);

        // Repeated accumulate on all-max data wraps past 2^24.
        run("wrap_first", 10, 1'b0, 0);
        for (int i = 0; i < 32; i++) run("wrap_acc", 10, 1'b1, 0);

        // Reset during COMPUTE at k=3, then a stray readdatavalid.
        fill_random(40);
        launch(40, 1'b0);
        while (cyc < 22) step();
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_result", 256'(result), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_mem_read", 256'(mem_read), 256'(0));
        check("midrst_done", 256'(done), 256'(0));
        rst_n = 1'b1;
        inject_req++;
        repeat (3) @(negedge clk);
        check("late_valid_result", 256'(result), 256'(0));
        check("late_valid_busy", 256'(busy), 256'(0));
        check("late_valid_mem_read", 256'(mem_read), 256'(0));
        for (int r = 0; r < ROWS; r++) model_c[r] = '0;
        run("after_rst", 40, 1'b1, 0);

        // Starts while busy and during the done pulse are ignored.
        fill_random(30);
        fill_random(45);
        model_run(30, 1'b0);
        launch(30, 1'b0);
        repeat (4) step();
        base_addr = ADW'(45);
        start     = 1'b1;
        step();
        start     = 1'b0;
        wait_done();
        finish_checks("ign_busy", exp_latency(lat, 0));
        base_addr = ADW'(45);
        start     = 1'b1;
        step();
        start     = 1'b0;
        check("ign_done_busy", 256'(busy), 256'(0));
        check("ign_done_done", 256'(done), 256'(0));
        step();
        check("ign_done_busy2", 256'(busy), 256'(0));
        check("ign_done_mem_read", 256'(mem_read), 256'(0));
        check("ign_done_result", 256'(result), 256'(model_vec()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
